clk_divider_prog: RTL

Runtime-programmable integer clock divider. It is the parametrised successor to the team's fixed divide-by-6 divider. Divide ratio and high-time are loaded through a valid/ready config port and applied glitch-free only at period boundaries. The block adds enable gating, a period-start tick and a config error flag. It sits in the clock-enable generation path, with outputs in the clk domain.

---
 rtl/clk_divider_prog.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/clk_divider_prog.sv
// ============================================================================
//  Module      : clk_divider_prog
//  Description : Runtime-programmable integer clock divider. Divide ratio and
//                high-time are loaded through a valid/ready config port and
//                take effect only at period boundaries. Provides enable
//                gating, a period-start tick and a config error pulse.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_divider_prog #(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_DIV  = 6,
    parameter int DEFAULT_HIGH = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] cfg_div_i,
    input  logic [CNT_W-1:0] cfg_high_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    output logic             cfg_err_o,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic [CNT_W-1:0] cur_div_o,
    output logic [CNT_W-1:0] cur_high_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] C_ZERO     = '0;
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TWO      = CNT_W'(2);
    localparam logic [CNT_W-1:0] C_DEF_DIV  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] C_DEF_HIGH = CNT_W'(DEFAULT_HIGH);

    // Run state: ST_RUN means the current cycle is an enabled cycle (en was
    // sampled high at the edge that started it).
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [CNT_W-1:0] cur_div_q,   cur_div_d;
    logic [CNT_W-1:0] cur_high_q,  cur_high_d;
    logic             pend_q,      pend_d;
    logic [CNT_W-1:0] pend_div_q,  pend_div_d;
    logic [CNT_W-1:0] pend_high_q, pend_high_d;
    logic             err_q,       err_d;
    logic             clk_out_q,   clk_out_d;
    logic             tick_q,      tick_d;

    logic             w_last;
    logic             w_apply;
    logic             w_xfer;
    logic             w_cfg_bad;
    logic [CNT_W-1:0] w_cfg_div_m1;
    logic [CNT_W-1:0] w_cfg_high_clamped;
    logic [CNT_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_high_nxt;
    logic [CNT_W-1:0] w_low_len_nxt;

    // ------------------------------------------------------------------------
    // Config-side decode: handshake, validity and high-time clamp
    // ------------------------------------------------------------------------
    // Clamp the requested high-time into 1..cfg_div-1 so low time never underflows.
    always_comb begin
        w_xfer             = cfg_valid_i && !pend_q;
        w_cfg_bad          = (cfg_div_i < C_TWO);
        w_cfg_div_m1       = cfg_div_i - C_ONE;
        w_cfg_high_clamped = cfg_high_i;
        if (cfg_high_i == C_ZERO) begin
            w_cfg_high_clamped = C_ONE;
        end else if (cfg_high_i > w_cfg_div_m1) begin
            w_cfg_high_clamped = w_cfg_div_m1;
        end
    end

    // ------------------------------------------------------------------------
    // Period boundary and apply decision
    // ------------------------------------------------------------------------
    // A pending setting swaps in at the end of a period or while stopped, so a
    // period never mixes old and new settings.
    always_comb begin
        w_last        = (cnt_q == (cur_div_q - C_ONE));
        w_apply       = pend_q && ((state_q == ST_RUN && w_last) || (state_q == ST_IDLE));
        w_div_nxt     = w_apply ? pend_div_q  : cur_div_q;
        w_high_nxt    = w_apply ? pend_high_q : cur_high_q;
        w_low_len_nxt = w_div_nxt - w_high_nxt;
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // Holds run state, counter, active/pending settings and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= C_ZERO;
            cur_div_q   <= C_DEF_DIV;
            cur_high_q  <= C_DEF_HIGH;
            pend_q      <= 1'b0;
            pend_div_q  <= C_ZERO;
            pend_high_q <= C_ZERO;
            err_q       <= 1'b0;
            clk_out_q   <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_div_q   <= cur_div_d;
            cur_high_q  <= cur_high_d;
            pend_q      <= pend_d;
            pend_div_q  <= pend_div_d;
            pend_high_q <= pend_high_d;
            err_q       <= err_d;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // Computes the next cycle's count and settings, then derives clk_out/tick
    // from that lookahead so both outputs come straight from flops.
    always_comb begin
        state_d     = state_q;
        cnt_d       = C_ZERO;
        cur_div_d   = w_div_nxt;
        cur_high_d  = w_high_nxt;
        pend_d      = pend_q;
        pend_div_d  = pend_div_q;
        pend_high_d = pend_high_q;
        err_d       = 1'b0;
        clk_out_d   = 1'b0;
        tick_d      = 1'b0;

        // Run state follows the sampled enable.
        case (state_q)
            ST_IDLE: state_d = en_i ? ST_RUN  : ST_IDLE;
            ST_RUN:  state_d = en_i ? ST_RUN  : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Counter: the first enabled cycle and every wrap start at 0; a
        // disabled cycle holds the counter at 0 (aborting the period).
        if (en_i && state_q == ST_RUN && !w_last) begin
            cnt_d = cnt_q + C_ONE;
        end

        // Pending slot: apply frees it; a new good request fills it. Both
        // cannot happen in one cycle since transfer requires an empty slot.
        if (w_apply) begin
            pend_d = 1'b0;
        end
        if (w_xfer) begin
            if (w_cfg_bad) begin
                err_d = 1'b1;
            end else begin
                pend_d      = 1'b1;
                pend_div_d  = cfg_div_i;
                pend_high_d = w_cfg_high_clamped;
            end
        end

        // Registered outputs for the upcoming cycle.
        clk_out_d = en_i && (cnt_d >= w_low_len_nxt);
        tick_d    = en_i && (cnt_d == C_ZERO);
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cfg_ready_o = !pend_q;
    assign cfg_err_o   = err_q;
    assign clk_out_o   = clk_out_q;
    assign tick_o      = tick_q;
    assign cur_div_o   = cur_div_q;
    assign cur_high_o  = cur_high_q;

endmodule

`default_nettype wire
